// File: rtl/lfsr_pkg.sv
// Shared constants and maximal-length tap table for the XNOR Fibonacci LFSR family.
package lfsr_pkg;

  localparam int LFSR_WID_MIN  = 3;
  localparam int LFSR_WID_MAX  = 32;
  localparam int LFSR_STEP_MIN = 1;
  localparam int LFSR_STEP_MAX = 8;

  function automatic logic [31:0] tap(int n);
    return 32'd1 << (n - 1);
  endfunction

  // Bit n (1-based) of the register is mask bit n-1.
  function automatic logic [31:0] lfsr_taps(int wid);
    logic [31:0] m;
    m = '0;
    case (wid)
      3:  m = tap(3)  | tap(2);
      4:  m = tap(4)  | tap(3);
      5:  m = tap(5)  | tap(3);
      6:  m = tap(6)  | tap(5);
      7:  m = tap(7)  | tap(6);
      8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:  m = tap(9)  | tap(5);
      10: m = tap(10) | tap(7);
      11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
      13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
      14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
      15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4);
      17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);
      19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
      20: m = tap(20) | tap(17);
      21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);
      23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17);
      25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
      27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
      28: m = tap(28) | tap(25);
      29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
      31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2)  | tap(1);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational XNOR Fibonacci shift: feedback enters at bit 0, cyc inverts it.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WID = 17
) (
  input  logic [WID-1:0] c,
  input  logic           cyc,
  output logic [WID-1:0] c_next
);

  localparam logic [WID-1:0] MASK = WID'(lfsr_taps(WID));

  logic fb;

  assign fb     = ~(^(c & MASK) ^ cyc);
  assign c_next = {c[WID-2:0], fb};

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised XNOR LFSR advancing STEP shifts per ce, with seed load, lock-up recovery
// and a wrap strobe whenever any sub-step lands on the reference (last loaded) value.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int             WID     = 17,
  parameter int             STEP    = 1,
  parameter logic [WID-1:0] RST_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           cyc,
  input  logic           ld,
  input  logic [WID-1:0] seed,
  output logic [WID-1:0] o,
  output logic           wrap,
  output logic           lock
);

  if (WID < LFSR_WID_MIN || WID > LFSR_WID_MAX) begin : g_bad_wid
    $error("lfsr_gen: WID=%0d outside legal range", WID);
  end
  if (STEP < LFSR_STEP_MIN || STEP > LFSR_STEP_MAX) begin : g_bad_step
    $error("lfsr_gen: STEP=%0d outside legal range", STEP);
  end
  if (&RST_VAL) begin : g_bad_rst_val
    $error("lfsr_gen: RST_VAL equals the all-ones lock-up state");
  end

  logic [WID-1:0]  ref_val;
  logic [WID-1:0]  chain [STEP+1];
  logic [STEP-1:0] hit;
  logic            locked;

  assign chain[0] = o;
  assign locked   = &o;

  // Sub-steps are chained combinationally; every intermediate is compared so a
  // period boundary falling inside a multi-bit advance is still reported.
  for (genvar i = 0; i < STEP; i++) begin : g_step
    lfsr_step #(.WID(WID)) u_step (
      .c      (chain[i]),
      .cyc    (cyc),
      .c_next (chain[i+1])
    );
    assign hit[i] = (chain[i+1] == ref_val);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      o       <= RST_VAL;
      ref_val <= RST_VAL;
      wrap    <= 1'b0;
      lock    <= 1'b0;
    end else if (ld) begin
      o       <= seed;
      ref_val <= seed;
      wrap    <= 1'b0;
      lock    <= 1'b0;
    end else if (ce) begin
      if (locked) begin
        // All ones is a fixed point of XNOR feedback; escape to zero, keep ref.
        o    <= '0;
        wrap <= 1'b0;
        lock <= 1'b1;
      end else begin
        o    <= chain[STEP];
        wrap <= |hit;
        lock <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
      lock <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed checks of lfsr_gen: WID=4 at STEP=1/2, plus a full WID=17 period against a tap 17,14 model.
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared controls for the two WID=4 instances.
  logic       rst = 1'b1, ce = 1'b0, cyc = 1'b0, ld = 1'b0;
  logic [3:0] seed = '0;
  logic [3:0] o4, o4s2;
  logic       wrap4, lock4, wrap4s2, lock4s2;

  logic        rst17 = 1'b1, ce17 = 1'b0;
  logic [16:0] seed17 = '0;
  logic [16:0] o17;
  logic        wrap17, lock17;

  lfsr_gen #(.WID(4), .STEP(1)) u_dut4 (
    .clk(clk), .rst(rst), .ce(ce), .cyc(cyc), .ld(ld), .seed(seed),
    .o(o4), .wrap(wrap4), .lock(lock4)
  );

  lfsr_gen #(.WID(4), .STEP(2)) u_dut4s2 (
    .clk(clk), .rst(rst), .ce(ce), .cyc(cyc), .ld(ld), .seed(seed),
    .o(o4s2), .wrap(wrap4s2), .lock(lock4s2)
  );

  lfsr_gen #(.WID(17), .STEP(8)) u_dut17 (
    .clk(clk), .rst(rst17), .ce(ce17), .cyc(1'b0), .ld(1'b0), .seed(seed17),
    .o(o17), .wrap(wrap17), .lock(lock17)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq [15];

  initial begin
    logic [16:0] m;
    logic        w;
    int          wraps;

    seq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
            4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

    // Reset state
    tick();
    check("rst_o", 32'(o4), 0);
    check("rst_wrap", 32'(wrap4), 0);
    check("rst_lock", 32'(lock4), 0);
    check("rst_o_s2", 32'(o4s2), 0);

    // Full period at STEP=1; STEP=2 runs alongside at twice the rate
    rst = 1'b0;
    ce  = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("seq_o[%0d]", i), 32'(o4), 32'(seq[i % 15]));
      check($sformatf("seq_wrap[%0d]", i), 32'(wrap4), 32'(i == 15));
      check($sformatf("seq_lock[%0d]", i), 32'(lock4), 0);
      check($sformatf("s2_o[%0d]", i), 32'(o4s2), 32'(seq[(2 * i) % 15]));
      check($sformatf("s2_wrap[%0d]", i), 32'(wrap4s2), 32'(i == 8 || i == 15));
    end
    ce = 1'b0;
    tick();
    check("hold_o", 32'(o4), 0);
    check("hold_wrap", 32'(wrap4), 0);

    // Seed at the lock-up value, then recovery
    ld   = 1'b1;
    seed = 4'hF;
    tick();
    check("ldF_o", 32'(o4), 32'hF);
    check("ldF_wrap", 32'(wrap4), 0);
    ld = 1'b0;
    ce = 1'b1;
    tick();
    check("lock_o", 32'(o4), 0);
    check("lock_pulse", 32'(lock4), 1);
    check("lock_wrap", 32'(wrap4), 0);
    check("lock_s2", 32'(lock4s2), 1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("post_lock_o[%0d]", i), 32'(o4), 32'(seq[i % 15]));
      check($sformatf("post_lock_wrap[%0d]", i), 32'(wrap4), 0);
      check($sformatf("post_lock_lock[%0d]", i), 32'(lock4), 0);
    end

    // Load wins over ce; new reference is 6 (sequence index 7)
    ld   = 1'b1;
    seed = 4'h6;
    tick();
    check("ld6_o", 32'(o4), 32'h6);
    check("ld6_wrap", 32'(wrap4), 0);
    ld = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("ld6_seq_o[%0d]", i), 32'(o4), 32'(seq[(7 + i) % 15]));
      check($sformatf("ld6_seq_wrap[%0d]", i), 32'(wrap4), 32'(i == 15));
    end

    // Advance to D, then reset with ce still high
    for (int i = 0; i < 13; i++) tick();
    check("pre_rst_o", 32'(o4), 32'hD);
    rst = 1'b1;
    tick();
    check("mid_rst_o", 32'(o4), 0);
    check("mid_rst_wrap", 32'(wrap4), 0);
    check("mid_rst_lock", 32'(lock4), 0);
    rst = 1'b0;
    ce  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("idle_o[%0d]", i), 32'(o4), 0);
      check($sformatf("idle_wrap[%0d]", i), 32'(wrap4), 0);
    end

    // cyc=1 at zero: parity 0 inverted twice gives fb=0, so o stays at ref
    ce  = 1'b1;
    cyc = 1'b1;
    tick();
    check("cyc_o", 32'(o4), 0);
    check("cyc_wrap", 32'(wrap4), 1);
    cyc = 1'b0;
    tick();
    check("cyc_off_o", 32'(o4), 32'h1);
    check("cyc_off_wrap", 32'(wrap4), 0);
    ce = 1'b0;

    // WID=17, STEP=8: one full period (131071 shifts) is reached mid-way through the 16384th ce
    check("w17_rst_o", 32'(o17), 0);
    rst17 = 1'b0;
    ce17  = 1'b1;
    m     = '0;
    wraps = 0;
    for (int i = 1; i <= 16384; i++) begin
      w = 1'b0;
      for (int s = 0; s < 8; s++) begin
        m = {m[15:0], ~(m[16] ^ m[13])};
        if (m == 17'd0) w = 1'b1;
      end
      tick();
      check("w17_o", 32'(o17), 32'(m));
      check("w17_wrap", 32'(wrap17), 32'(w));
      check("w17_lock", 32'(lock17), 0);
      if (wrap17) wraps++;
    end
    ce17 = 1'b0;
    check("w17_wrap_count", 32'(wraps), 1);
    check("w17_final_o", 32'(o17), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
